// File: rtl/outbuf_pkt_fifo.sv
// rtl/outbuf_pkt_fifo.sv - DEPTH-entry parity word-set FIFO serialised onto a valid/ready beat bus
// Ports: clk, rst (async, active high), outbuf_flush (sync clear)
//        engine side: eng_outbuf_wr_req, eng_outbuf_dout_reg, outbuf_eng_wr_ack, outbuf_eng_full
//        control side: outbuf_empty, outbuf_cnt, outbuf_m_beats, outbuf_ovf_err
//        beat side: outbuf_dout, outbuf_dout_val, outbuf_dout_last, outbuf_dout_rdy
// Build option: OUTBUF_OVF_CHK_EN enables the sticky overflow flag
module outbuf_pkt_fifo #(
    parameter int PCK_TREE_XOR_UNITS_NUM = 128,
    parameter int W                      = 4,
    parameter int PACKET_LENGTH          = 2,
    parameter int ENTRY_W                = PCK_TREE_XOR_UNITS_NUM * W * PACKET_LENGTH,
    parameter int OUT_BUS_W              = 128,
    parameter int BEATS_MAX              = ENTRY_W / OUT_BUS_W,
    parameter int DEPTH                  = 4,
    localparam int CW                    = $clog2(DEPTH) + 1,
    localparam int BW                    = $clog2(BEATS_MAX) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 outbuf_flush,
    input  logic                 eng_outbuf_wr_req,
    input  logic [ENTRY_W-1:0]   eng_outbuf_dout_reg,
    output logic                 outbuf_eng_wr_ack,
    output logic                 outbuf_eng_full,
    output logic                 outbuf_empty,
    output logic [CW-1:0]        outbuf_cnt,
    input  logic [BW-1:0]        outbuf_m_beats,
    output logic [OUT_BUS_W-1:0] outbuf_dout,
    output logic                 outbuf_dout_val,
    output logic                 outbuf_dout_last,
    input  logic                 outbuf_dout_rdy,
    output logic                 outbuf_ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int BI = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [BW-1:0]          nbeats_q, nbeats_d;
    logic [BW-1:0]          mb_clamped;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   full_q, empty_q, ack_q;
    logic                   push, pop, last;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [BEATS_MAX-1:0][OUT_BUS_W-1:0] head_beats;

    // Full comes from the registered count, so a push is refused at full
    // even when the head is popping in the same cycle.
    assign push = eng_outbuf_wr_req & ~full_q & ~outbuf_flush;
    assign last = (state_q == SEND) && (beat_q == nbeats_q - BW'(1));
    assign pop  = last & outbuf_dout_rdy & ~outbuf_flush;

    always_comb begin
        if (outbuf_m_beats == '0)
            mb_clamped = BW'(1);
        else if (outbuf_m_beats > BW'(BEATS_MAX))
            mb_clamped = BW'(BEATS_MAX);
        else
            mb_clamped = outbuf_m_beats;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (outbuf_flush)
            cnt_d = '0;
        else if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // Serialiser next state. The beat count is latched per entry so that
    // outbuf_m_beats changes never disturb an entry already in flight.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        nbeats_d = nbeats_q;
        if (outbuf_flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q != '0) begin
                        state_d  = SEND;
                        beat_d   = '0;
                        nbeats_d = mb_clamped;
                    end
                end
                SEND: begin
                    if (outbuf_dout_rdy) begin
                        beat_d = beat_q + BW'(1);
                        if (last) begin
                            beat_d = '0;
                            if (cnt_q > CW'(1))
                                nbeats_d = mb_clamped;
                            else
                                state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            nbeats_q <= BW'(1);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            nbeats_q <= nbeats_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CW'(DEPTH));
            empty_q  <= (cnt_d == '0) && (state_d == IDLE);
            ack_q    <= push;
            if (outbuf_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= eng_outbuf_dout_reg;
    end

`ifdef OUTBUF_OVF_CHK_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (outbuf_flush)
            ovf_q <= 1'b0;
        else if (eng_outbuf_wr_req && full_q)
            ovf_q <= 1'b1;
    end
    assign outbuf_ovf_err = ovf_q;
`else
    assign outbuf_ovf_err = 1'b0;
`endif

    assign head_beats        = mem[rd_ptr];
    assign outbuf_dout_val   = (state_q == SEND);
    assign outbuf_dout       = outbuf_dout_val ? head_beats[beat_q[BI-1:0]] : '0;
    assign outbuf_dout_last  = last;
    assign outbuf_eng_wr_ack = ack_q;
    assign outbuf_eng_full   = full_q;
    assign outbuf_empty      = empty_q;
    assign outbuf_cnt        = cnt_q;

endmodule

// File: tb/tb_outbuf_pkt_fifo.sv
// tb/tb_outbuf_pkt_fifo.sv - queue-model checked bench for outbuf_pkt_fifo
module tb_outbuf_pkt_fifo;

    localparam int UN = 4, WW = 4, PL = 2, EW = 32, OB = 8, BM = 4, DP = 4;
    localparam int CW = 3, BW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, wr_req, rdy;
    logic [EW-1:0] din;
    logic [BW-1:0] mbeats;
    logic          ack, full, empty, val, lst, ovf;
    logic [CW-1:0] cnt;
    logic [OB-1:0] dout;

    always #5 clk = ~clk;

    outbuf_pkt_fifo #(
        .PCK_TREE_XOR_UNITS_NUM(UN), .W(WW), .PACKET_LENGTH(PL), .ENTRY_W(EW),
        .OUT_BUS_W(OB), .BEATS_MAX(BM), .DEPTH(DP)
    ) dut (
        .clk(clk), .rst(rst), .outbuf_flush(flush),
        .eng_outbuf_wr_req(wr_req), .eng_outbuf_dout_reg(din),
        .outbuf_eng_wr_ack(ack), .outbuf_eng_full(full), .outbuf_empty(empty),
        .outbuf_cnt(cnt), .outbuf_m_beats(mbeats), .outbuf_dout(dout),
        .outbuf_dout_val(val), .outbuf_dout_last(lst), .outbuf_dout_rdy(rdy),
        .outbuf_ovf_err(ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue of stored entries plus the entry currently being sent.
    logic [EW-1:0] mq[$];
    bit  busy;
    int  nb, beat;
    bit  ack_m, ovf_m;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [EW-1:0] h;
        logic [OB-1:0] ed;
        ed = '0;
        if (busy) begin
            h  = mq[0];
            ed = h[beat*OB +: OB];
        end
        chk("val", val, busy);
        chk("dout", dout, ed);
        chk("last", lst, busy && (beat == nb - 1));
        chk("cnt", cnt, mq.size());
        chk("full", full, mq.size() == DP);
        chk("empty", empty, (mq.size() == 0) && !busy);
        chk("ack", ack, ack_m);
        chk("ovf", ovf, ovf_m);
    endtask

    task automatic model_reset();
        mq.delete();
        busy = 0; nb = 1; beat = 0; ack_m = 0; ovf_m = 0;
    endtask

    task automatic model(bit req, logic [EW-1:0] d, bit fl, bit rd, int mb);
        int sz;
        bit isfull, islast;
        int cl;
        sz     = mq.size();
        isfull = (sz == DP);
        islast = busy && (beat == nb - 1);
        cl     = (mb == 0) ? 1 : ((mb > BM) ? BM : mb);
        if (fl) begin
            mq.delete();
            busy = 0; beat = 0; ack_m = 0; ovf_m = 0;
            return;
        end
`ifdef OUTBUF_OVF_CHK_EN
        if (req && isfull) ovf_m = 1;
`endif
        ack_m = req && !isfull;
        if (!busy) begin
            if (sz > 0) begin busy = 1; nb = cl; beat = 0; end
        end else if (rd) begin
            if (islast) begin
                void'(mq.pop_front());
                if (sz - 1 > 0) begin nb = cl; beat = 0; end
                else busy = 0;
            end else begin
                beat++;
            end
        end
        if (ack_m) mq.push_back(d);
    endtask

    task automatic step(bit req, logic [EW-1:0] d, bit fl, bit rd, int mb);
        @(negedge clk);
        check_all();
        wr_req = req; din = d; flush = fl; rdy = rd; mbeats = BW'(mb);
        model(req, d, fl, rd, mb);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        wr_req = 0; flush = 0; rdy = 1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit rp [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
        rst = 1'b1; flush = 0; wr_req = 0; rdy = 0; din = '0; mbeats = 3'd4;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // single entry, four beats
        step(1, 32'hDDCCBBAA, 0, 1, 4);
        repeat (8) step(0, 0, 0, 1, 4);

        // overfill with downstream stalled, then drain
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 4);
        repeat (2) step(0, 0, 0, 0, 4);
        repeat (20) step(0, 0, 0, 1, 4);

        // short entries back to back, then zero clamps to one beat
        step(1, 32'h44332211, 0, 1, 2);
        step(1, 32'h88776655, 0, 1, 2);
        repeat (7) step(0, 0, 0, 1, 2);
        step(1, 32'h0F0E0D0C, 0, 1, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        step(1, 32'h12345678, 0, 1, 7);
        repeat (7) step(0, 0, 0, 1, 7);

        // ready toggling mid-entry
        step(1, 32'hCAFEF00D, 0, 0, 4);
        step(0, 0, 0, 0, 4);
        for (int i = 0; i < 12; i++) step(0, 0, 0, rp[i], 1);
        repeat (3) step(0, 0, 0, 1, 1);

        // push at full against a same-cycle last-beat pop, then wrap
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 32'hBADBAD00, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, $urandom, 0, 1, 1);
        repeat (8) step(0, 0, 0, 1, 1);

        // flush mid-transfer
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 3);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 1, 3);
        step(1, 32'h55555555, 1, 1, 3);
        repeat (4) step(0, 0, 0, 1, 3);

        // asynchronous reset mid-transfer
        step(1, $urandom, 0, 1, 4);
        step(1, $urandom, 0, 1, 4);
        step(0, 0, 0, 1, 4);
        mid_reset();
        repeat (4) step(0, 0, 0, 1, 4);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7));
        repeat (30) step(0, 0, 0, 1, 2);
        @(negedge clk);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
